// File: rtl/crt_timing_gen.sv
// rtl/crt_timing_gen.sv - parametrised CRT/VGA raster timing generator
//
// Divides the system clock down to a pixel-rate enable and scans a raster of
// H_TOTAL x V_TOTAL positions, producing syncs, coordinates and strobes.
//
// Ports:
//   Clock        system clock
//   Reset        synchronous reset, active-high
//   hsync/vsync  sync outputs, active level H_POL / V_POL
//   xpos/ypos    current raster position (CW bits)
//   video_on     high inside the visible window
//   pix_tick     one-clock pixel-rate enable
//   line_start   one-clock pulse when xpos becomes 0
//   frame_start  one-clock pulse when (xpos,ypos) becomes (0,0)
//   frame_count  8-bit frame counter, present only with CRT_FRAME_COUNTER_EN
//
// Optional feature macro: CRT_FRAME_COUNTER_EN

module crt_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYS_MHZ   = 100,
    parameter int PIX_MHZ   = 25,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CW        = 10
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          video_on,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
`ifdef CRT_FRAME_COUNTER_EN
    ,
    output logic [7:0]    frame_count
`endif
);

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV       = SYS_MHZ / PIX_MHZ;
    localparam int DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam logic HP      = (H_POL != 0);
    localparam logic VP      = (V_POL != 0);

    generate
        if (SYS_MHZ % PIX_MHZ != 0) begin : g_bad_ratio
            $error("crt_timing_gen: SYS_MHZ must be a multiple of PIX_MHZ");
        end
        if (DIV < 1) begin : g_bad_div
            $error("crt_timing_gen: SYS_MHZ/PIX_MHZ must be at least 1");
        end
        if ((longint'(1) << CW) < longint'(MAX_TOTAL)) begin : g_bad_cw
            $error("crt_timing_gen: CW too narrow for the raster totals");
        end
        if (H_BACK < 1 || V_BACK < 1) begin : g_bad_back
            $error("crt_timing_gen: back porches must be at least 1");
        end
    endgenerate

    logic [DW-1:0] dcnt;
    logic [DW-1:0] d_nxt;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          hs_act;
    logic          vs_act;
    logic          vis_nxt;
    logic          at_line;
    logic          at_frame;

    // Registered pix_tick marks the cycle where dcnt==DIV-1; the counters
    // step on the edge that closes that cycle, and every flag is decoded
    // from the post-step values so all outputs land on the same edge.
    always_comb begin
        d_nxt = (dcnt == DW'(DIV - 1)) ? '0 : dcnt + 1'b1;
        x_nxt = xpos;
        y_nxt = ypos;
        if (pix_tick) begin
            if (xpos == CW'(H_TOTAL - 1)) begin
                x_nxt = '0;
                y_nxt = (ypos == CW'(V_TOTAL - 1)) ? '0 : ypos + 1'b1;
            end else begin
                x_nxt = xpos + 1'b1;
            end
        end
        hs_act   = (x_nxt >= CW'(H_VISIBLE + H_FRONT)) &&
                   (x_nxt <  CW'(H_VISIBLE + H_FRONT + H_SYNC));
        vs_act   = (y_nxt >= CW'(V_VISIBLE + V_FRONT)) &&
                   (y_nxt <  CW'(V_VISIBLE + V_FRONT + V_SYNC));
        vis_nxt  = (x_nxt < CW'(H_VISIBLE)) && (y_nxt < CW'(V_VISIBLE));
        at_line  = pix_tick && (x_nxt == '0);
        at_frame = at_line && (y_nxt == '0);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dcnt        <= '0;
            pix_tick    <= 1'b0;
            xpos        <= CW'(H_TOTAL - 1);
            ypos        <= CW'(V_TOTAL - 1);
            hsync       <= ~HP;
            vsync       <= ~VP;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            dcnt        <= d_nxt;
            pix_tick    <= (d_nxt == DW'(DIV - 1));
            xpos        <= x_nxt;
            ypos        <= y_nxt;
            hsync       <= hs_act ~^ HP;
            vsync       <= vs_act ~^ VP;
            video_on    <= vis_nxt;
            line_start  <= at_line;
            frame_start <= at_frame;
        end
    end

`ifdef CRT_FRAME_COUNTER_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_count <= '0;
        end else if (at_frame) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/crt_timing_gen.md
# crt_timing_gen

Parametrised CRT/VGA raster timing generator, the next-generation replacement for the fixed 640x480 CRT controller used by the Pong top level. Derives a pixel-rate tick from the system clock and produces horizontal/vertical sync, pixel coordinates, a visible-region flag and line/frame strobes for any resolution, porch set, sync polarity and clock ratio. Game and renderer modules consume `xpos`/`ypos`/`video_on` and the strobes.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels, ≥1)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines, ≥1)
- `SYS_MHZ`, 100, system clock frequency
- `PIX_MHZ`, 25, pixel clock frequency
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level
- `CW`, 10, coordinate width
- `Clock`  in  1  system clock
- `Reset`  in  1  synchronous reset, active-high
- `hsync`  out  1  horizontal sync, polarity `H_POL`
- `vsync`  out  1  vertical sync, polarity `V_POL`
- `xpos`  out  CW  current horizontal count
- `ypos`  out  CW  current vertical count
- `video_on`  out  1  high when `xpos<H_VISIBLE` and `ypos<V_VISIBLE`
- `pix_tick`  out  1  one-clock pixel-rate enable
- `line_start`  out  1  one-clock pulse when `xpos` becomes 0
- `frame_start`  out  1  one-clock pulse when (`xpos`,`ypos`) becomes (0,0)
- `frame_count`  out  8  frame counter (present only with `CRT_FRAME_COUNTER_EN`)

## Operation
- `H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK`; `V_TOTAL` likewise. `DIV = SYS_MHZ/PIX_MHZ`.
- Elaboration errors: `SYS_MHZ % PIX_MHZ != 0`; `DIV < 1`; `2^CW < max(H_TOTAL,V_TOTAL)`; `H_BACK` or `V_BACK` of 0.
- Divider `dcnt` counts 0..DIV-1 and wraps. `pix_tick` is high on the clock where `dcnt==DIV-1`. With DIV=1, `pix_tick` is constantly high outside reset.
- On each tick, `xpos` increments and wraps at `H_TOTAL-1` → 0. On that wrap, `ypos` increments and wraps at `V_TOTAL-1` → 0.
- hsync is active for `H_VISIBLE+H_FRONT ≤ xpos < H_VISIBLE+H_FRONT+H_SYNC`, otherwise inactive. vsync uses the same rule on `ypos` with the V parameters.
- All outputs are registered and mutually aligned. `hsync`, `vsync`, `video_on`, `line_start` and `frame_start` are decoded from the next counter values, so they change on the same edge as `xpos`/`ypos`.
- `line_start` and `frame_start` are single system-clock pulses, not pixel-period wide. They rise on the same edge as the counter transition.

## Timing
- Reset values:
  - `dcnt=0`, `xpos=H_TOTAL-1`, `ypos=V_TOTAL-1`
  - `hsync=!H_POL`, `vsync=!V_POL`
  - `video_on=0`, `pix_tick=0`, `line_start=0`, `frame_start=0`, `frame_count=0`
- Reset is honoured on any edge, mid-line or mid-frame. It overrides a coincident tick.
- After reset release, `pix_tick` first asserts on the DIV-th clock.
- The clock edge following that first `pix_tick` produces (0,0), `video_on=1`, `line_start=1` and `frame_start=1`.
- Line period: `H_TOTAL*DIV` clocks. Frame period: `H_TOTAL*V_TOTAL*DIV` clocks.
- Pipeline latency from counter change to sync/flag change is 0 clocks; all outputs are aligned.

## Configuration
- `CRT_FRAME_COUNTER_EN` defined:
  - Port `frame_count[7:0]` exists.
  - It increments on the same edge `frame_start` rises and wraps 255→0.
  - It resets to 0.
- `CRT_FRAME_COUNTER_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Default parameters; hold `Reset` 5 clocks, then release → `pix_tick` high on the 4th clock. Next edge: `xpos=0`, `ypos=0`, `video_on=1`, `frame_start` and `line_start` each high for exactly 1 clock.
- Defaults, one line → `hsync` low exactly while `xpos` is 656..751 (96 ticks = 384 clocks). Line period = 3200 clocks. `video_on` is high for 640 ticks per visible line.
- Defaults, one full frame → `vsync` low only for `ypos` 490..491. Frame period = 1,680,000 clocks. `video_on` is high for 307,200 ticks per frame.
- Assert `Reset` for 1 clock at `xpos=300`, `ypos=200`, coinciding with a tick → next edge `xpos=799`, `ypos=524`, `hsync=1`, `vsync=1`, `video_on=0`.
- `SYS_MHZ=PIX_MHZ=25`, `H_POL=1`, `V_POL=1` → `pix_tick` constantly 1 after reset. `hsync` is 1 only for `xpos` 656..751. Line period = 800 clocks.
- With `CRT_FRAME_COUNTER_EN`, run 257 frames → `frame_count` is 1..255, then 0, then 1. It changes only on `frame_start` edges.
